fir_coef_loader: RTL
====================

Name: fir_coef_loader

Overview:
Configuration sequencer for the upsampler's direct-form FIR coefficient port. It holds two shadow banks of L coefficients written by the config host. On command it streams a selected bank into the filter through a load strobe plus data pair, paced by a programmable gap. It runs in the filter's config clock domain. It reports busy, done, error and a checksum so software can switch filter responses safely.

Parameters:
- L, 16, number of taps per bank; power of two, 2..64.
- DW, 16, coefficient width.
- GAP, 0, idle cycles inserted between consecutive load strobes (0..15).
- REVERSE, 1, 1 emits coef[L-1] first down to coef[0]; 0 emits coef[0] first.

Ports:
- i_clk  in  1  config clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_wr_en  in  1  host coefficient write strobe.
- i_wr_addr  in  1+log2(L)  MSB = bank, low bits = tap index.
- i_wr_data  in  DW  coefficient value.
- i_start  in  1  single-cycle stream request.
- i_bank_sel  in  1  bank to stream; sampled with i_start.
- o_load_parameter  out  1  load strobe to filter.
- o_parameter_data  out  DW  coefficient to filter; valid only when strobe is high.
- o_busy  out  1  stream in progress.
- o_done  out  1  one-cycle pulse after the last strobe.
- o_err  out  1  one-cycle pulse on a rejected command or write.
- o_active_bank  out  1  bank most recently streamed to completion.
- o_checksum  out  DW  modulo-2^DW sum of the coefficients streamed; updated at o_done.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - All outputs go to 0.
  - FSM goes to IDLE; counters go to 0.
  - Coefficient banks are not reset (contents undefined until written).
- FSM states: IDLE, LOAD, WAIT, DONE.
  - IDLE, i_start=1: latch i_bank_sel, clear the running sum, go to LOAD.
  - LOAD: drive o_load_parameter=1 and o_parameter_data=bank[idx]; add the coefficient to the sum.
    - If this is the last tap, go to DONE.
    - Otherwise, if GAP>0, go to WAIT; else stay in LOAD with the next idx.
  - WAIT: count GAP cycles with strobe=0 and data=0, then go to LOAD.
  - DONE, one cycle: o_done=1, o_busy=0, o_checksum<=sum, o_active_bank<=latched bank; go to IDLE.
- Tap index: starts at L-1 when REVERSE=1 (decrementing), or 0 when REVERSE=0 (incrementing).
- Outputs are registered:
  - i_start at cycle N gives the first strobe at N+1.
  - Strobe k (k=0..L-1) is at N+1+k*(GAP+1).
  - o_done is at N+1+(L-1)*(GAP+1)+1.
- o_busy is high from N+1 through the last strobe cycle inclusive.
- Writes:
  - Accepted in any state unless they target the latched bank while o_busy=1.
  - A rejected write pulses o_err for one cycle and leaves memory unchanged.
  - A write to the other bank during streaming is accepted.
- i_start while busy or in DONE: ignored, o_err pulses, the current stream is unaffected.
- i_start and i_wr_en in the same IDLE cycle, same bank as i_bank_sel: the write is rejected (o_err), the start is accepted.
- If both rejection causes occur in one cycle, o_err is a single pulse.
- Reset mid-stream: the strobe drops immediately. After reset release the block is IDLE, o_active_bank=0 and o_checksum=0. The filter holds a partial load that software must re-stream.
- Sum arithmetic: DW-bit unsigned wrap; coefficients are treated as raw bits.

Decomposition:
- Package fir_coef_pkg holds:
  - the FSM state enum (IDLE/LOAD/WAIT/DONE);
  - the address-width function log2(L)+1;
  - default constants L_DEF=16, DW_DEF=16.
- One natural sub-module, coef_bank_ram: 2*L x DW register file with one write port and one asynchronous read port. It is instanced once.
- The FSM, counters and checksum stay in the top module.

Test Plan:
- Write bank0 coef[i]=i+1 (i=0..15); start bank0 at cycle N, GAP=0, REVERSE=1 -> strobe high N+1..N+16 with data 16,15,...,1; o_done at N+17; o_checksum=0x0088; o_active_bank=0.
- Same data, GAP=2, REVERSE=0 -> strobes at N+1, N+4, ..., N+46 with data 1..16; data=0 between strobes; o_done at N+47.
- Bank1 all 0xFFFF; start bank1 -> checksum 0xFFF0 (wrap); o_active_bank=1.
- During a bank0 stream: i_start pulse -> o_err one cycle, stream and checksum unchanged. Write addr bank0 idx3=0xAAAA -> o_err, later readback stream still shows 4. Write bank1 idx3 -> accepted.
- Same-cycle i_start(bank0) + write bank0 idx0=0x1234 -> o_err, stream emits the old value 1.
- Assert i_rst=0 at strobe 5 -> strobe drops asynchronously, o_busy=0, no o_done. After release, restarting bank0 gives the full 16-strobe sequence.

Source files
------------

// File: rtl/fir_coef_loader_pkg.sv
// fir_coef_pkg: shared FSM state type, address-width helper and default sizes
package fir_coef_pkg;
  localparam int L_DEF = 16;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  function automatic int addr_w(input int l);
    return $clog2(l) + 1;
  endfunction
endpackage

// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if: host write/command port and filter load port of the coefficient loader
interface fir_coef_loader_if #(
  parameter int L = fir_coef_pkg::L_DEF,
  parameter int DW = fir_coef_pkg::DW_DEF
);
  localparam int AW = fir_coef_pkg::addr_w(L);
  logic i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic i_start;
  logic i_bank_sel;
  logic o_load_parameter;
  logic [DW-1:0] o_parameter_data;
  logic o_busy;
  logic o_done;
  logic o_err;
  logic o_active_bank;
  logic [DW-1:0] o_checksum;
  modport slave (
    input i_wr_en, i_wr_addr, i_wr_data, i_start, i_bank_sel,
    output o_load_parameter, o_parameter_data, o_busy, o_done, o_err, o_active_bank, o_checksum
  );
  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_bank_sel,
    input o_load_parameter, o_parameter_data, o_busy, o_done, o_err, o_active_bank, o_checksum
  );
endinterface

// File: rtl/fir_coef_loader_coef_bank_ram.sv
// coef_bank_ram: two banks of L coefficients, one write port, one asynchronous read port
module coef_bank_ram #(
  parameter int L = fir_coef_pkg::L_DEF,
  parameter int DW = fir_coef_pkg::DW_DEF,
  parameter int AW = fir_coef_pkg::addr_w(L)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2*L];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a selected shadow coefficient bank into the FIR load port with
// programmable strobe spacing, reporting busy/done/error and a wrap-around checksum.
module fir_coef_loader #(
  parameter int L = fir_coef_pkg::L_DEF,
  parameter int DW = fir_coef_pkg::DW_DEF,
  parameter int GAP = 0,
  parameter int REVERSE = 1
) (
  input logic i_clk,
  input logic i_rst,
  fir_coef_loader_if.slave bus
);
  import fir_coef_pkg::*;
  localparam int IW = $clog2(L);
  localparam int AW = addr_w(L);
  localparam logic [IW-1:0] FIRST = (REVERSE != 0) ? IW'(L-1) : '0;
  localparam logic [IW-1:0] LAST = (REVERSE != 0) ? '0 : IW'(L-1);
  localparam logic [3:0] GAP_M1 = 4'((GAP > 0) ? GAP - 1 : 0);
  state_t r_state;
  logic [IW-1:0] r_idx;
  logic [3:0] r_gap;
  logic r_bank, r_load, r_busy, r_done, r_err, r_act;
  logic [DW-1:0] r_data, r_sum, r_cks;
  logic [DW-1:0] w_rd_data;
  logic [IW-1:0] w_next, w_rd_idx;
  logic w_rd_bank, w_start_ok, w_start_rej, w_wr_rej, w_wr_bank;
  assign w_next = (REVERSE != 0) ? r_idx - IW'(1) : r_idx + IW'(1);
  assign w_start_ok = bus.i_start && r_state == IDLE;
  assign w_start_rej = bus.i_start && r_state != IDLE;
  assign w_wr_bank = bus.i_wr_addr[AW-1];
  // the bank being streamed is frozen, including the one a same-cycle start is about to latch
  assign w_wr_rej = bus.i_wr_en && ((r_busy && w_wr_bank == r_bank) ||
                                    (w_start_ok && w_wr_bank == bus.i_bank_sel));
  assign w_rd_bank = (r_state == IDLE) ? bus.i_bank_sel : r_bank;
  assign w_rd_idx = (r_state == IDLE) ? FIRST : (r_state == LOAD) ? w_next : r_idx;
  coef_bank_ram #(.L(L), .DW(DW), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (bus.i_wr_en && !w_wr_rej),
    .i_waddr (bus.i_wr_addr),
    .i_wdata (bus.i_wr_data),
    .i_raddr ({w_rd_bank, w_rd_idx}),
    .o_rdata (w_rd_data)
  );
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_gap <= '0;
      r_bank <= 1'b0;
      r_load <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_act <= 1'b0;
      r_data <= '0;
      r_sum <= '0;
      r_cks <= '0;
    end else begin
      r_err <= w_start_rej || w_wr_rej;
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.i_start) begin
            r_bank <= bus.i_bank_sel;
            r_idx <= FIRST;
            r_load <= 1'b1;
            r_data <= w_rd_data;
            r_sum <= w_rd_data;
            r_busy <= 1'b1;
            r_state <= LOAD;
          end
        LOAD:
          if (r_idx == LAST) begin
            r_state <= DONE;
            r_load <= 1'b0;
            r_data <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_cks <= r_sum;
            r_act <= r_bank;
          end else if (GAP > 0) begin
            r_state <= WAIT;
            r_load <= 1'b0;
            r_data <= '0;
            r_gap <= GAP_M1;
            r_idx <= w_next;
          end else begin
            r_idx <= w_next;
            r_data <= w_rd_data;
            r_sum <= r_sum + w_rd_data;
          end
        WAIT:
          if (r_gap == 4'd0) begin
            r_state <= LOAD;
            r_load <= 1'b1;
            r_data <= w_rd_data;
            r_sum <= r_sum + w_rd_data;
          end else r_gap <= r_gap - 4'd1;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  assign bus.o_load_parameter = r_load;
  assign bus.o_parameter_data = r_data;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_err = r_err;
  assign bus.o_active_bank = r_act;
  assign bus.o_checksum = r_cks;
endmodule
